// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative multiply/divide engine (shift-add multiply,
// restoring divide, one iteration per clock) that stalls new ops while busy.
module hilo_muldiv_unit #(
    parameter int                WIDTH        = 32,
    parameter logic [WIDTH-1:0]  HILO_RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MTHI  = 3'b001;
    localparam logic [2:0] OP_MTLO  = 3'b010;
    localparam logic [2:0] OP_MULT  = 3'b011;
    localparam logic [2:0] OP_MULTU = 3'b100;
    localparam logic [2:0] OP_DIV   = 3'b101;
    localparam logic [2:0] OP_DIVU  = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic n);
        return n ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x, input logic n);
        return n ? (~x + 1'b1) : x;
    endfunction

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] p;        // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   b_op;     // multiplicand or divisor magnitude
    logic               is_div, neg_res, neg_rem, b_zero;

    logic               accept, md_op, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign busy      = (state != IDLE);
    assign stall     = op_valid & busy;
    assign accept    = op_valid & ~busy & ~flush;
    assign md_op     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = signed_op & rs_data[WIDTH-1];
    assign b_neg     = signed_op & rt_data[WIDTH-1];
    assign a_mag     = cneg_w(rs_data, a_neg);
    assign b_mag     = cneg_w(rt_data, b_neg);

    // One iteration step for each algorithm
    logic [WIDTH:0]     mul_upper, rem_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign mul_upper = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b_op} : '0);
    assign mul_next  = {mul_upper, p[WIDTH-1:1]};
    assign rem_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign div_ge    = rem_shift >= {1'b0, b_op};
    assign div_sub   = WIDTH'(rem_shift - {1'b0, b_op});
    assign div_next  = div_ge ? {div_sub, p[WIDTH-2:0], 1'b1}
                              : {rem_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};

    assign prod  = cneg_2w(p, neg_res);
    assign q_fix = b_zero ? '1 : cneg_w(p[WIDTH-1:0], neg_res);
    assign r_fix = cneg_w(p[2*WIDTH-1:WIDTH], neg_rem);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && md_op) state_nxt = RUN;
            RUN:     if (flush) state_nxt = IDLE;
                     else if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == RUN) ? cnt + 1'b1 : '0;
            done  <= (state == FIX) && !flush;
        end
    end

    // Engine datapath: operands latched on accept, iterated while running
    always_ff @(posedge clk) begin
        if (state == IDLE && accept && md_op) begin
            is_div  <= (op == OP_DIV) || (op == OP_DIVU);
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            b_zero  <= (rt_data == '0);
            if ((op == OP_DIV) || (op == OP_DIVU)) begin
                p    <= {{WIDTH{1'b0}}, a_mag};
                b_op <= b_mag;
            end else begin
                p    <= {{WIDTH{1'b0}}, b_mag};
                b_op <= a_mag;
            end
        end else if (state == RUN) begin
            p <= is_div ? div_next : mul_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= HILO_RST_VAL;
            lo <= HILO_RST_VAL;
        end else if (accept && op == OP_MTHI) begin
            hi <= rs_data;
        end else if (accept && op == OP_MTLO) begin
            lo <= rs_data;
        end else if (state == FIX && !flush) begin
            hi <= is_div ? r_fix : prod[2*WIDTH-1:WIDTH];
            lo <= is_div ? q_fix : prod[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit (WIDTH=32): MTHI/MTLO, mul/div results, stall, flush, reset.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, op_valid, flush;
    logic [2:0]    op;
    logic [W-1:0]  rs_data, rt_data;
    logic          busy, stall, done;
    logic [W-1:0]  hi, lo;

    int total = 0;
    int bad   = 0;

    hilo_muldiv_unit #(.WIDTH(W), .HILO_RST_VAL('0)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one mul/div op, then count busy cycles and done pulses until the engine idles.
    task automatic run_md(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input string tag);
        int busy_cyc = 0;
        int done_cnt = 0;
        @(negedge clk);
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        op_valid = 1'b0; op = 3'b000;
        for (int i = 0; i < 100 && busy; i++) begin
            busy_cyc++;
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd33);
        chk({tag, "_done_early"}, 64'(done_cnt), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        chk({tag, "_done_drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; op_valid = 1'b0; flush = 1'b0; op = 3'b000;
        rs_data = '0; rt_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        // MTHI then MTLO on consecutive cycles
        op_valid = 1'b1; op = 3'b001; rs_data = 32'h12345678;
        @(negedge clk);
        chk("mthi_busy", 64'(busy), 64'd0);
        op = 3'b010; rs_data = 32'h9ABCDEF0;
        @(negedge clk);
        op_valid = 1'b0; op = 3'b000;
        chk("mt_hi", 64'(hi), 64'h12345678);
        chk("mt_lo", 64'(lo), 64'h9ABCDEF0);
        chk("mt_busy", 64'(busy), 64'd0);

        run_md(3'b011, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");
        run_md(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        run_md(3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min");
        run_md(3'b011, 32'd5,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC, "mult_mix");
        run_md(3'b101, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        run_md(3'b110, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, "divu_zero");
        run_md(3'b101, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_zero");
        run_md(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");
        run_md(3'b110, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_plain");

        // MTLO held while a DIVU is running: stalled, then accepted after busy falls
        @(negedge clk);
        op_valid = 1'b1; op = 3'b110; rs_data = 32'd1003; rt_data = 32'd10;
        @(negedge clk);
        op_valid = 1'b0; op = 3'b000;
        repeat (4) @(negedge clk);
        op_valid = 1'b1; op = 3'b010; rs_data = 32'h000000AA;
        #1;
        chk("stall_hi", 64'(stall), 64'd1);
        @(negedge clk);
        chk("stall_lo_stable", 64'(lo), 64'd14);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        chk("stall_drop", 64'(stall), 64'd0);
        chk("stall_div_lo", 64'(lo), 64'd100);
        chk("stall_div_hi", 64'(hi), 64'd3);
        @(negedge clk);
        op_valid = 1'b0; op = 3'b000;
        chk("late_mtlo_lo", 64'(lo), 64'h000000AA);
        chk("late_mtlo_hi", 64'(hi), 64'd3);

        // Reserved op and flush-blocked MTHI have no effect
        op_valid = 1'b1; op = 3'b111; rs_data = 32'h55555555;
        @(negedge clk);
        op = 3'b001; flush = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; op = 3'b000; flush = 1'b0;
        chk("noeff_busy", 64'(busy), 64'd0);
        chk("noeff_hi", 64'(hi), 64'd3);
        chk("noeff_lo", 64'(lo), 64'h000000AA);

        // Flush at cycle 10 of a MULT
        op_valid = 1'b1; op = 3'b011; rs_data = 32'd9; rt_data = 32'd9;
        @(negedge clk);
        op_valid = 1'b0; op = 3'b000;
        repeat (8) @(negedge clk);
        chk("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        chk("flush_hi", 64'(hi), 64'd3);
        chk("flush_lo", 64'(lo), 64'h000000AA);
        @(negedge clk);
        chk("flush_done_late", 64'(done), 64'd0);

        // Reset at cycle 20 of a MULT
        op_valid = 1'b1; op = 3'b011; rs_data = 32'd9; rt_data = 32'd9;
        @(negedge clk);
        op_valid = 1'b0; op = 3'b000;
        repeat (18) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        repeat (40) @(negedge clk);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hi_late", 64'(hi), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
